execute_sequencer: RTL and testbench

Execute stage directly downstream of the instruction decoder. Each cycle it accepts one decoded instruction (decoder flags plus operands) when ready, and performs the operation:
- add: single cycle;
- multiply: iterative shift-add over DATA_WIDTH cycles;
- load-from-switches: single cycle;
- wait: stall until a go pulse.

It produces a registered write-back result, write enable and destination address for the register file, and back-pressures instruction issue while multi-cycle work is in flight.

---
 rtl/exec_pkg.sv | 30 +++
 rtl/execute_sequencer_if.sv | 28 ++
 rtl/execute_sequencer_mul.sv | 47 ++++
 rtl/execute_sequencer.sv | 90 +++++++++
 tb/tb_execute_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: FSM states, instruction classes and the
// flag-priority decoder used on the accept cycle.
package exec_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CL_ADD  = 3'd0,
        CL_MUL  = 3'd1,
        CL_LOAD = 3'd2,
        CL_WAIT = 3'd3,
        CL_NOP  = 3'd4
    } class_e;

    // Decoder flags overlap; wait outranks load, load outranks add, and a bare
    // write-result flag means multiply.
    function automatic class_e decode_class(input logic f_wait, input logic f_load,
                                            input logic f_add, input logic f_wr_res);
        if (f_wait)        return CL_WAIT;
        else if (f_load)   return CL_LOAD;
        else if (f_add)    return CL_ADD;
        else if (f_wr_res) return CL_MUL;
        else               return CL_NOP;
    endfunction

endpackage

// File: rtl/execute_sequencer_if.sv
// Decoder-to-execute issue handshake plus register-file write-back bus.
interface exec_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 2
);
    logic                      instr_valid;
    logic                      instr_ready;
    logic                      f_add, f_imm, f_wait, f_load, f_wr_res;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     op_a, op_b, imm, switches;
    logic                      go;
    logic                      wr_en;
    logic [REG_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      busy;

    modport master (
        output instr_valid, f_add, f_imm, f_wait, f_load, f_wr_res, rd,
               op_a, op_b, imm, switches, go,
        input  instr_ready, wr_en, wr_addr, wr_data, busy
    );

    modport slave (
        input  instr_valid, f_add, f_imm, f_wait, f_load, f_wr_res, rd,
               op_a, op_b, imm, switches, go,
        output instr_ready, wr_en, wr_addr, wr_data, busy
    );
endinterface

// File: rtl/execute_sequencer_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH
// cycles, low DATA_WIDTH bits of the product.
module seq_multiplier #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] mcand, mplier, acc, acc_next;
    logic [CW-1:0]         cnt;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    // The last step is presented combinationally so the result can be
    // registered on the same edge the counter expires.
    assign done     = busy && (cnt == '0);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(DATA_WIDTH - 1);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == '0) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/execute_sequencer.sv
// Execute stage: accepts decoded instructions, runs add/load/mul/wait and
// drives a registered write-back port into the register file.
module execute_sequencer
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 2
) (
    input  logic clk,
    input  logic rst,
    exec_if.slave bus
);
    state_e                    state_q, state_d;
    class_e                    cls;
    logic                      accept, instr_ready, mul_start, mul_done;
    logic [DATA_WIDTH-1:0]     b_eff, sum, product;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      wr_en_q;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;

    assign cls    = decode_class(bus.f_wait, bus.f_load, bus.f_add, bus.f_wr_res);
    assign b_eff  = bus.f_imm ? bus.imm : bus.op_b;
    assign sum    = bus.op_a + b_eff;
    assign accept = bus.instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (cls == CL_MUL)       state_d = ST_MUL;
                else if (cls == CL_WAIT) state_d = ST_WAIT;
            end
            ST_MUL:  if (mul_done) state_d = ST_IDLE;
            ST_WAIT: if (bus.go)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state_q == ST_IDLE);
        bus.busy    = (state_q == ST_MUL) || (state_q == ST_WAIT);
        mul_start   = accept && (cls == CL_MUL);
    end

    assign bus.instr_ready = instr_ready;

    seq_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.op_a),
        .b       (b_eff),
        .busy    (),
        .done    (mul_done),
        .product (product)
    );

    // Write-back register: one strobe per writing instruction, address/data
    // held between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (mul_start) rd_q <= bus.rd;
            if (accept && bus.f_wr_res && (cls == CL_ADD || cls == CL_LOAD)) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= bus.rd;
                wr_data_q <= (cls == CL_LOAD) ? bus.switches : sum;
            end else if (mul_done && state_q == ST_MUL) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= rd_q;
                wr_data_q <= product;
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule

// File: tb/tb_execute_sequencer.sv
// Scoreboard bench for execute_sequencer: expected write-backs are queued at
// issue and compared whenever the DUT strobes wr_en.
module tb_execute_sequencer;
    localparam int DW = 8;
    localparam int AW = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    wb_t  sb[$];

    exec_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

    execute_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_instr(input logic fw, fl, fa, fi, fr, input logic [AW-1:0] rd_i,
                             input logic [DW-1:0] a, b, im, sw);
        bus.f_wait = fw; bus.f_load = fl; bus.f_add = fa; bus.f_imm = fi; bus.f_wr_res = fr;
        bus.rd = rd_i; bus.op_a = a; bus.op_b = b; bus.imm = im; bus.switches = sw;
    endtask

    // Reference behaviour of one instruction, independent of the RTL structure.
    task automatic push_expect(input logic fw, fl, fa, fi, fr, input logic [AW-1:0] rd_i,
                               input logic [DW-1:0] a, b, im, sw);
        logic [DW-1:0] bb;
        wb_t e;
        bb = fi ? im : b;
        e.addr = rd_i;
        if (fw) return;
        else if (fl) begin if (!fr) return; e.data = sw; end
        else if (fa) begin if (!fr) return; e.data = DW'((32'(a) + 32'(bb)) % 256); end
        else if (fr) e.data = DW'((32'(a) * 32'(bb)) % 256);
        else return;
        sb.push_back(e);
    endtask

    // Drive one instruction, wait (bounded) for acceptance; returns in cycle T+1.
    task automatic issue(input logic fw, fl, fa, fi, fr, input logic [AW-1:0] rd_i,
                         input logic [DW-1:0] a, b, im, sw, input bit push);
        int n;
        set_instr(fw, fl, fa, fi, fr, rd_i, a, b, im, sw);
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 100) begin tick(); n++; end
        if (n == 100) chk("issue_timeout", 0, 1);
        if (push) push_expect(fw, fl, fa, fi, fr, rd_i, a, b, im, sw);
        tick();
        bus.instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            if (sb.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                wb_t e;
                e = sb.pop_front();
                chk("sb_addr", 32'(bus.wr_addr), 32'(e.addr));
                chk("sb_data", 32'(bus.wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.go = 1'b0;
        set_instr(0, 0, 0, 0, 0, '0, '0, '0, '0, '0);
        tick(3);
        rst = 1'b0;
        tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.instr_ready), 1);

        // ADD with wrap
        issue(0, 0, 1, 0, 1, 2'd1, 8'd200, 8'd100, 8'd0, 8'd0, 1);
        chk("add_wr_en", 32'(bus.wr_en), 1);
        chk("add_data", 32'(bus.wr_data), 44);
        chk("add_ready", 32'(bus.instr_ready), 1);
        tick();
        chk("add_single_strobe", 32'(bus.wr_en), 0);
        chk("hold_data", 32'(bus.wr_data), 44);

        // ADDI then LOAD back to back
        issue(0, 0, 1, 1, 1, 2'd3, 8'd5, 8'd77, 8'd3, 8'd0, 1);
        chk("addi_data", 32'(bus.wr_data), 8);
        chk("addi_wr_en", 32'(bus.wr_en), 1);
        issue(0, 1, 0, 0, 1, 2'd2, 8'd0, 8'd0, 8'd0, 8'ha5, 1);
        chk("load_data", 32'(bus.wr_data), 32'h a5);
        chk("load_wr_en", 32'(bus.wr_en), 1);
        chk("load_addr", 32'(bus.wr_addr), 2);

        // ADD without write-result flag writes nothing
        issue(0, 0, 1, 0, 0, 2'd0, 8'd1, 8'd1, 8'd0, 8'd0, 1);
        chk("add_nowr", 32'(bus.wr_en), 0);
        tick();

        // MULI 13*11 with a queued ADD held valid during the multiply
        issue(0, 0, 0, 1, 1, 2'd3, 8'd13, 8'd0, 8'd11, 8'd0, 1);
        set_instr(0, 0, 1, 0, 1, 2'd1, 8'd20, 8'd22, 8'd99, 8'd0);
        bus.instr_valid = 1'b1;
        push_expect(0, 0, 1, 0, 1, 2'd1, 8'd20, 8'd22, 8'd99, 8'd0);
        for (int i = 1; i <= DW; i++) begin
            chk("mul_ready_low", 32'(bus.instr_ready), 0);
            chk("mul_busy", 32'(bus.busy), 1);
            chk("mul_no_wr", 32'(bus.wr_en), 0);
            tick();
        end
        chk("mul_wr_en", 32'(bus.wr_en), 1);
        chk("mul_data", 32'(bus.wr_data), 143);
        chk("mul_ready_back", 32'(bus.instr_ready), 1);
        tick();
        bus.instr_valid = 1'b0;
        chk("queued_add_wr", 32'(bus.wr_en), 1);
        chk("queued_add_data", 32'(bus.wr_data), 42);
        tick();

        // Truncated 0xFF*0xFF
        issue(0, 0, 0, 0, 1, 2'd2, 8'hff, 8'hff, 8'd0, 8'd0, 1);
        tick(DW);
        chk("mulff_wr_en", 32'(bus.wr_en), 1);
        chk("mulff_data", 32'(bus.wr_data), 1);
        tick();

        // Reset in the middle of a multiply aborts it
        issue(0, 0, 0, 0, 1, 2'd1, 8'd7, 8'd9, 8'd0, 8'd0, 0);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_wr_addr", 32'(bus.wr_addr), 0);
        chk("abort_wr_data", 32'(bus.wr_data), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_ready", 32'(bus.instr_ready), 1);
        for (int i = 0; i < 12; i++) begin
            chk("abort_quiet", 32'(bus.wr_en), 0);
            tick();
        end

        // WAIT with f_wr_res: go on the accept cycle ignored, released at T+5
        set_instr(1, 0, 0, 0, 1, 2'd3, 8'd1, 8'd2, 8'd3, 8'd4);
        bus.instr_valid = 1'b1;
        bus.go = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.go = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("wait_ready_low", 32'(bus.instr_ready), 0);
            chk("wait_busy", 32'(bus.busy), 1);
            tick();
        end
        chk("wait_ready_t5", 32'(bus.instr_ready), 0);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        chk("wait_release", 32'(bus.instr_ready), 1);
        chk("wait_busy_off", 32'(bus.busy), 0);
        chk("wait_no_wr", 32'(bus.wr_en), 0);

        // NOP and stray go pulses in IDLE
        issue(0, 0, 0, 0, 0, 2'd2, 8'd9, 8'd9, 8'd9, 8'd9, 1);
        chk("nop_wr", 32'(bus.wr_en), 0);
        chk("nop_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 3; i++) begin
            bus.go = 1'b1;
            tick();
            bus.go = 1'b0;
            chk("idle_go_busy", 32'(bus.busy), 0);
            chk("idle_go_ready", 32'(bus.instr_ready), 1);
        end
        tick(2);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
